// File: rtl/pe_pkg.sv
// Shared types for the modular-arithmetic PE array: opcodes, parameter sets and
// the sequencer state encoding.
package pe_pkg;

    typedef enum logic [4:0] {
        MADD   = 5'd0,
        MSUB   = 5'd1,
        MMUL   = 5'd2,
        CT_BFO = 5'd3,
        GS_BFO = 5'd4,
        MCOPY  = 5'd5
    } pe_instr_t;

    typedef enum logic [4:0] {
        KEM_512  = 5'd0,
        KEM_768  = 5'd1,
        KEM_1024 = 5'd2,
        DSA_44   = 5'd3,
        DSA_65   = 5'd4,
        DSA_87   = 5'd5
    } pe_alg_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } seq_state_e;

endpackage

// File: rtl/pe_lat_pipe.sv
// LAT-deep valid+address shift register that tracks reads in flight through the
// PE array; the output stage is the write-back strobe.
module pe_lat_pipe #(
    parameter int unsigned LAT    = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              empty
);

    logic [LAT-1:0]             valid_q;
    logic [LAT-1:0][ADDR_W-1:0] addr_q;
    logic [LAT-1:0]             behind;

    // Shifts every cycle; bubbles are simply entries with valid clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    // Empty means nothing valid behind the output stage, so an output-stage
    // valid seen together with empty is the final write of the stream.
    always_comb begin
        behind        = valid_q;
        behind[LAT-1] = 1'b0;
    end

    assign empty     = ~|behind;
    assign out_valid = valid_q[LAT-1];
    assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Command sequencer for the PE array: latches one vector command, streams group
// reads, and retires the matching writes after the fixed pipeline latency.
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned NUM    = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_instr,
    input  logic [4:0]        cmd_alg,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              hold,
    output logic [4:0]        pe_instr,
    output logic [4:0]        pe_alg,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    if (LAT < 1 || LAT > 8 || NUM == 0) begin : g_param_check
        $error("pe_seq_ctrl: LAT must be 1..8 and NUM nonzero");
    end

    seq_state_e        state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   last_idx;
    pe_instr_t         instr_q;
    pe_alg_t           alg_q;
    logic [ADDR_W-1:0] src0_q, src1_q, dst_q;
    logic              accept;
    logic              pipe_empty;

    assign accept   = (state_q == StIdle) && cmd_valid;
    assign last_idx = len_q - (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (!hold && idx_q == last_idx) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_en && pipe_empty) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        rd_en     = (state_q == StIssue) && !hold;
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (rd_en) begin
            idx_d = idx_q + (ADDR_W+1)'(1);
        end
    end

    // Command fields are only sampled on accept, so later cmd_* changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            len_q   <= '0;
            instr_q <= MADD;
            alg_q   <= KEM_512;
            src0_q  <= '0;
            src1_q  <= '0;
            dst_q   <= '0;
        end else begin
            idx_q <= idx_d;
            if (accept) begin
                len_q   <= cmd_len;
                instr_q <= pe_instr_t'(cmd_instr);
                alg_q   <= pe_alg_t'(cmd_alg);
                src0_q  <= cmd_src0;
                src1_q  <= cmd_src1;
                dst_q   <= cmd_dst;
            end
        end
    end

    assign pe_instr = instr_q;
    assign pe_alg   = alg_q;
    assign rd_addr0 = src0_q + idx_q[ADDR_W-1:0];
    assign rd_addr1 = src1_q + idx_q[ADDR_W-1:0];

    pe_lat_pipe #(
        .LAT    (LAT),
        .ADDR_W (ADDR_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_addr   (dst_q + idx_q[ADDR_W-1:0]),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .empty     (pipe_empty)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with LAT=3, ADDR_W=8.
module tb_pe_seq_ctrl;
    import pe_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_instr;
    logic [4:0] cmd_alg;
    logic [7:0] cmd_src0;
    logic [7:0] cmd_src1;
    logic [7:0] cmd_dst;
    logic [8:0] cmd_len;
    logic       hold;
    logic [4:0] pe_instr;
    logic [4:0] pe_alg;
    logic       rd_en;
    logic [7:0] rd_addr0;
    logic [7:0] rd_addr1;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       rd_log   [0:299];
    logic [7:0] a0_log   [0:299];
    logic [7:0] a1_log   [0:299];
    logic       wr_log   [0:299];
    logic [7:0] wa_log   [0:299];
    logic       done_log [0:299];
    logic       rdy_log  [0:299];

    always #5 clk = ~clk;

    pe_seq_ctrl #(
        .NUM    (4),
        .ADDR_W (8),
        .LAT    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_instr (cmd_instr),
        .cmd_alg   (cmd_alg),
        .cmd_src0  (cmd_src0),
        .cmd_src1  (cmd_src1),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .hold      (hold),
        .pe_instr  (pe_instr),
        .pe_alg    (pe_alg),
        .rd_en     (rd_en),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .done      (done)
    );

    // Entered at edge+1; offers one command, then logs cycles T+1..T+ncyc.
    task automatic run_cmd(input logic [4:0] instr, input logic [4:0] alg,
                           input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] d,
                           input logic [8:0] len, input logic [15:0] hold_mask,
                           input int ncyc);
        cmd_instr = instr;
        cmd_alg   = alg;
        cmd_src0  = s0;
        cmd_src1  = s1;
        cmd_dst   = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_instr = 5'($urandom);
        cmd_src0  = 8'($urandom);
        cmd_src1  = 8'($urandom);
        cmd_dst   = 8'($urandom);
        cmd_len   = 9'($urandom);
        for (int n = 1; n <= ncyc; n++) begin
            hold = (n < 16) ? hold_mask[n] : 1'b0;
            #2;
            rd_log[n]   = rd_en;
            a0_log[n]   = rd_addr0;
            a1_log[n]   = rd_addr1;
            wr_log[n]   = wr_en;
            wa_log[n]   = wr_addr;
            done_log[n] = done;
            rdy_log[n]  = cmd_ready;
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        hold      = 1'b0;
        cmd_instr = '0;
        cmd_alg   = '0;
        cmd_src0  = '0;
        cmd_src1  = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({cmd_ready, rd_en, wr_en, done, busy} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b exp 10000", {cmd_ready, rd_en, wr_en, done, busy});
        end
        tests_run++;
        if ({pe_instr, pe_alg, rd_addr0, rd_addr1, wr_addr} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h exp 0", {pe_instr, pe_alg, rd_addr0, rd_addr1, wr_addr});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_release got %b exp 100", {cmd_ready, busy, done});
        end
    endtask

    task automatic test_basic;
        logic [10:1] exp_rd, exp_wr, exp_done;
        exp_rd   = 10'b0000001111;
        exp_wr   = 10'b0001111000;
        exp_done = 10'b0010000000;
        run_cmd(MADD, KEM_768, 8'h10, 8'h40, 8'h80, 9'd4, 16'h0, 10);
        for (int n = 1; n <= 10; n++) begin
            tests_run++;
            if ({rd_log[n], wr_log[n], done_log[n]} !== {exp_rd[n], exp_wr[n], exp_done[n]}) begin
                tests_failed++;
                $display("FAIL basic_strobes cyc=%0d got rd/wr/done=%b%b%b exp %b%b%b", n,
                         rd_log[n], wr_log[n], done_log[n], exp_rd[n], exp_wr[n], exp_done[n]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({a0_log[1+k], a1_log[1+k], wa_log[4+k]} !==
                {8'h10 + 8'(k), 8'h40 + 8'(k), 8'h80 + 8'(k)}) begin
                tests_failed++;
                $display("FAIL basic_addr k=%0d got %h/%h/%h exp %h/%h/%h", k, a0_log[1+k],
                         a1_log[1+k], wa_log[4+k], 8'h10 + 8'(k), 8'h40 + 8'(k), 8'h80 + 8'(k));
            end
        end
        tests_run++;
        if ({rdy_log[8], rdy_log[9]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_ready got %b%b exp 01", rdy_log[8], rdy_log[9]);
        end
        tests_run++;
        if ({pe_instr, pe_alg} !== {MADD, KEM_768}) begin
            tests_failed++;
            $display("FAIL basic_instr_alg got %h/%h exp %h/%h", pe_instr, pe_alg, MADD, KEM_768);
        end
    endtask

    task automatic test_hold;
        logic [12:1] exp_rd, exp_wr, exp_done;
        int          rd_off [4];
        int          wr_off [4];
        exp_rd   = 12'b000000111001;
        exp_wr   = 12'b000111001000;
        exp_done = 12'b001000000000;
        rd_off   = '{1, 4, 5, 6};
        wr_off   = '{4, 7, 8, 9};
        run_cmd(MADD, KEM_512, 8'h10, 8'h40, 8'h80, 9'd4, 16'h000C, 12);
        for (int n = 1; n <= 12; n++) begin
            tests_run++;
            if ({rd_log[n], wr_log[n], done_log[n]} !== {exp_rd[n], exp_wr[n], exp_done[n]}) begin
                tests_failed++;
                $display("FAIL hold_strobes cyc=%0d got rd/wr/done=%b%b%b exp %b%b%b", n,
                         rd_log[n], wr_log[n], done_log[n], exp_rd[n], exp_wr[n], exp_done[n]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({a0_log[rd_off[k]], a1_log[rd_off[k]], wa_log[wr_off[k]]} !==
                {8'h10 + 8'(k), 8'h40 + 8'(k), 8'h80 + 8'(k)}) begin
                tests_failed++;
                $display("FAIL hold_addr k=%0d got %h/%h/%h", k, a0_log[rd_off[k]],
                         a1_log[rd_off[k]], wa_log[wr_off[k]]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [9:1] exp_rd, exp_wr, exp_done;
        logic [7:0] exp_a0 [3];
        logic [7:0] exp_a1 [3];
        logic [7:0] exp_wa [3];
        exp_rd   = 9'b000000111;
        exp_wr   = 9'b000111000;
        exp_done = 9'b001000000;
        exp_a0   = '{8'hFE, 8'hFF, 8'h00};
        exp_a1   = '{8'h7F, 8'h80, 8'h81};
        exp_wa   = '{8'hFF, 8'h00, 8'h01};
        // hold raised during DRAIN must not disturb the stream.
        run_cmd(MSUB, KEM_1024, 8'hFE, 8'h7F, 8'hFF, 9'd3, 16'h0030, 9);
        for (int n = 1; n <= 9; n++) begin
            tests_run++;
            if ({rd_log[n], wr_log[n], done_log[n]} !== {exp_rd[n], exp_wr[n], exp_done[n]}) begin
                tests_failed++;
                $display("FAIL wrap_strobes cyc=%0d got rd/wr/done=%b%b%b exp %b%b%b", n,
                         rd_log[n], wr_log[n], done_log[n], exp_rd[n], exp_wr[n], exp_done[n]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({a0_log[1+k], a1_log[1+k], wa_log[4+k]} !== {exp_a0[k], exp_a1[k], exp_wa[k]}) begin
                tests_failed++;
                $display("FAIL wrap_addr k=%0d got %h/%h/%h exp %h/%h/%h", k, a0_log[1+k],
                         a1_log[1+k], wa_log[4+k], exp_a0[k], exp_a1[k], exp_wa[k]);
            end
        end
    endtask

    task automatic test_zero_back_to_back;
        int rd_cnt   = 0;
        int wr_cnt   = 0;
        int done_cyc = -1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_ready_pre got %b exp 1", cmd_ready);
        end
        cmd_instr = MADD;
        cmd_alg   = KEM_512;
        cmd_src0  = 8'h00;
        cmd_src1  = 8'h00;
        cmd_dst   = 8'h00;
        cmd_len   = 9'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Cycle T+1: second command already offered and held.
        cmd_instr = CT_BFO;
        cmd_alg   = DSA_44;
        cmd_src0  = 8'h20;
        cmd_src1  = 8'h30;
        cmd_dst   = 8'h40;
        cmd_len   = 9'd2;
        #2;
        tests_run++;
        if ({done, rd_en, wr_en, cmd_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL zero_done got done/rd/wr/rdy=%b exp 1000", {done, rd_en, wr_en, cmd_ready});
        end
        @(posedge clk);
        #3;
        tests_run++;
        if ({cmd_ready, done, pe_instr} !== {2'b10, MADD}) begin
            tests_failed++;
            $display("FAIL b2b_idle got rdy/done=%b%b instr=%h exp 10/%h", cmd_ready, done,
                     pe_instr, MADD);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        #2;
        tests_run++;
        if ({pe_instr, pe_alg, rd_en, rd_addr0} !== {CT_BFO, DSA_44, 1'b1, 8'h20}) begin
            tests_failed++;
            $display("FAIL b2b_accept got instr=%h alg=%h rd=%b a0=%h exp %h/%h/1/20", pe_instr,
                     pe_alg, rd_en, rd_addr0, CT_BFO, DSA_44);
        end
        rd_cnt = int'(rd_en);
        for (int n = 4; n <= 10; n++) begin
            @(posedge clk);
            #3;
            rd_cnt += int'(rd_en);
            wr_cnt += int'(wr_en);
            if (done && done_cyc < 0) done_cyc = n;
        end
        tests_run++;
        if (done_cyc != 8 || rd_cnt != 2 || wr_cnt != 2) begin
            tests_failed++;
            $display("FAIL b2b_second got done_cyc=%0d rd=%0d wr=%0d exp 8/2/2", done_cyc,
                     rd_cnt, wr_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int late_wr   = 0;
        int late_done = 0;
        int not_rdy   = 0;
        cmd_instr = MMUL;
        cmd_alg   = KEM_1024;
        cmd_src0  = 8'h00;
        cmd_src1  = 8'h50;
        cmd_dst   = 8'hA0;
        cmd_len   = 9'd8;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        // Cycle T+10 is inside DRAIN with writes still pending.
        tests_run++;
        if ({busy, rd_en, wr_en, wr_addr} !== {3'b101, 8'hA6}) begin
            tests_failed++;
            $display("FAIL rstmid_pre got busy/rd/wr=%b%b%b wa=%h exp 101/a6", busy, rd_en,
                     wr_en, wr_addr);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({cmd_ready, rd_en, wr_en, done, busy} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl got %b exp 10000", {cmd_ready, rd_en, wr_en, done, busy});
        end
        tests_run++;
        if ({pe_instr, pe_alg, rd_addr0, rd_addr1, wr_addr} !== 34'h0) begin
            tests_failed++;
            $display("FAIL rstmid_data got %h exp 0", {pe_instr, pe_alg, rd_addr0, rd_addr1, wr_addr});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #2;
            late_wr   += int'(wr_en);
            late_done += int'(done);
            not_rdy   += int'(!cmd_ready);
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (late_wr != 0 || late_done != 0 || not_rdy != 0) begin
            tests_failed++;
            $display("FAIL rstmid_after got wr=%0d done=%0d notrdy=%0d exp 0/0/0", late_wr,
                     late_done, not_rdy);
        end
    endtask

    task automatic test_full_length;
        int seen_rd [256];
        int seen_wr [256];
        int rd_cnt   = 0;
        int wr_cnt   = 0;
        int done_cnt = 0;
        int bad_addr = 0;
        int bad_a1   = 0;
        for (int a = 0; a < 256; a++) begin
            seen_rd[a] = 0;
            seen_wr[a] = 0;
        end
        run_cmd(MADD, KEM_512, 8'h00, 8'h20, 8'h30, 9'h100, 16'h0, 262);
        for (int n = 1; n <= 262; n++) begin
            if (rd_log[n]) begin
                rd_cnt++;
                seen_rd[a0_log[n]]++;
                if (a1_log[n] !== a0_log[n] + 8'h20) bad_a1++;
            end
            if (wr_log[n]) begin
                wr_cnt++;
                seen_wr[wa_log[n]]++;
            end
            done_cnt += int'(done_log[n]);
        end
        for (int a = 0; a < 256; a++) begin
            if (seen_rd[a] != 1 || seen_wr[a] != 1) bad_addr++;
        end
        tests_run++;
        if (rd_cnt != 256 || wr_cnt != 256) begin
            tests_failed++;
            $display("FAIL full_counts got rd=%0d wr=%0d exp 256/256", rd_cnt, wr_cnt);
        end
        tests_run++;
        if (bad_addr != 0 || bad_a1 != 0) begin
            tests_failed++;
            $display("FAIL full_coverage got bad_addr=%0d bad_a1=%0d exp 0/0", bad_addr, bad_a1);
        end
        tests_run++;
        if (done_log[260] !== 1'b1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL full_done got done@260=%b count=%0d exp 1/1", done_log[260], done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_wrap();
        test_zero_back_to_back();
        test_reset_mid();
        test_full_length();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
